perf_stat_bank: RTL

PERF_STAT_BANK -- requirements
Module: perf_stat_bank

---
 rtl/perf_stat_bank_pkg.sv | 20 ++
 rtl/stat_counter.sv | 39 +++
 rtl/perf_stat_bank.sv | 99 +++++++++
 3 files changed

// File: rtl/perf_stat_bank_pkg.sv
// Shared definitions for the performance statistics bank: FSM encoding,
// legal parameter ranges and the readout-select width helper.
package perf_stat_bank_pkg;

    localparam int MIN_CH    = 1;
    localparam int MAX_CH    = 16;
    localparam int MIN_CNT_W = 8;
    localparam int MAX_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stat_counter.sv
// One event counter with soft clear, sticky overflow flag and a choice of
// saturating or wrapping behaviour at all-ones.
module stat_counter #(
    parameter int CNT_W = 16,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    logic [CNT_W-1:0] cnt_plus1;

    assign cnt_plus1 = cnt + CNT_W'(1);

    // NOTE: registers use <= so every flop samples pre-edge values; = here would race between blocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (cnt == ALL_ONES) begin
                if (!SAT) cnt <= '0;
            end else begin
                cnt <= cnt_plus1;
                if (cnt_plus1 == ALL_ONES) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_stat_bank.sv
// Bank of NUM_CH event counters plus a RUN-cycle counter, with a run/halt FSM,
// snapshot shadow registers and a registered shadow readout port.
module perf_stat_bank
    import perf_stat_bank_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 16,
    parameter bit  SAT    = 1'b1,
    localparam int RD_W   = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              tick,
    input  logic              start,
    input  logic              halt,
    input  logic [NUM_CH-1:0] ev,
    input  logic              clr,
    input  logic              snap_req,
    input  logic [RD_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic              snap_valid,
    output logic [NUM_CH:0]   ovf,
    output logic [1:0]        state
);

    if (NUM_CH < MIN_CH || NUM_CH > MAX_CH || CNT_W < MIN_CNT_W || CNT_W > MAX_CNT_W) begin : g_param_check
        $error("perf_stat_bank: NUM_CH or CNT_W outside supported range");
    end

    state_t           st;
    logic             count_en;
    logic             snap_take;
    logic [NUM_CH:0]  inc_vec;
    logic [CNT_W-1:0] live   [NUM_CH+1];
    logic [CNT_W-1:0] shadow [NUM_CH+1];
    logic [CNT_W-1:0] rd_next;

    // Index NUM_CH of live/shadow is the RUN-cycle counter.
    assign count_en  = (st == ST_RUN) && tick && !halt;
    assign inc_vec   = {count_en, ev & {NUM_CH{count_en}}};
    assign snap_take = snap_req || ((st == ST_RUN) && halt && !clr);

    for (genvar i = 0; i <= NUM_CH; i++) begin : g_cnt
        stat_counter #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_cnt (
            .clk   (clk),
            .rst_n (RST),
            .inc   (inc_vec[i]),
            .clr   (clr),
            .cnt   (live[i]),
            .ovf   (ovf[i])
        );
    end

    assign cyc_cnt = live[NUM_CH];
    assign state   = st;

    always_ff @(posedge clk) begin
        if (!RST) begin
            st <= ST_IDLE;
        end else if (clr) begin
            st <= ST_IDLE;
        end else begin
            case (st)
                ST_IDLE:   if (start) st <= ST_RUN;
                ST_RUN:    if (halt)  st <= ST_HALTED;
                ST_HALTED: if (!halt) st <= ST_RUN;
                default:   st <= ST_IDLE;
            endcase
        end
    end

    // NOTE: rd_next gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        rd_next = shadow[NUM_CH];
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == RD_W'(i)) rd_next = shadow[i];
        end
    end

    // NOTE: the shadow array is a handful of flops that must read zero after reset, so it is cleared explicitly.
    always_ff @(posedge clk) begin
        if (!RST) begin
            for (int i = 0; i <= NUM_CH; i++) shadow[i] <= '0;
            snap_valid <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (snap_take) begin
                for (int i = 0; i <= NUM_CH; i++) shadow[i] <= live[i];
                snap_valid <= 1'b1;
            end
            rd_data <= rd_next;
        end
    end

endmodule
